// File: rtl/stump_sequencer_pkg.sv
// rtl/stump_sequencer_pkg.sv - shared state codes, opcodes and CC bit positions for the Stump sequencer
package stump_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_EXECUTE = 2'b01,
        ST_MEMORY  = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADC  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_SBC  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_BCC  = 3'b110;
    localparam logic [2:0] OP_LDST = 3'b111;

    localparam int CC_N = 3;
    localparam int CC_Z = 2;
    localparam int CC_V = 1;
    localparam int CC_C = 0;

endpackage

// File: rtl/stump_branch_eval.sv
// rtl/stump_branch_eval.sv - combinational branch condition evaluation against the condition codes
module stump_branch_eval
    import stump_sequencer_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] cc,
    output logic       taken
);

    logic w_n, w_z, w_v, w_c;
    logic w_base;

    assign w_n = cc[CC_N];
    assign w_z = cc[CC_Z];
    assign w_v = cc[CC_V];
    assign w_c = cc[CC_C];

    // Conditions come in pairs: the odd code is the complement of the even one.
    always_comb begin
        w_base = 1'b1;
        case (cond[3:1])
            3'd0: w_base = 1'b1;
            3'd1: w_base = ~(w_c | w_z);
            3'd2: w_base = ~w_c;
            3'd3: w_base = ~w_z;
            3'd4: w_base = ~w_v;
            3'd5: w_base = ~w_n;
            3'd6: w_base = ~(w_n ^ w_v);
            3'd7: w_base = ~((w_n ^ w_v) | w_z);
            default: w_base = 1'b1;
        endcase
    end

    assign taken = w_base ^ cond[0];

endmodule

// File: rtl/stump_sequencer.sv
// rtl/stump_sequencer.sv - FETCH/EXECUTE/MEMORY state, IR, CC and retired-instruction counter
module stump_sequencer
    import stump_sequencer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      mem_data,
    input  logic             mem_ready,
    input  logic             cc_en,
    input  logic [3:0]       flags_in,
    output logic [1:0]       state,
    output logic [15:0]      ir,
    output logic [3:0]       cc,
    output logic             branch_taken,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count
);

    state_t           r_state;
    logic [15:0]      r_ir;
    logic [3:0]       r_cc;
    logic [CNT_W-1:0] r_count;

    logic [2:0] w_op;
    logic       w_cond_true;
    logic       w_retire;

    assign w_op = r_ir[15:13];

    stump_branch_eval u_branch_eval (
        .cond  (r_ir[11:8]),
        .cc    (r_cc),
        .taken (w_cond_true)
    );

    assign w_retire = ((r_state == ST_EXECUTE) && (w_op != OP_LDST)) ||
                      ((r_state == ST_MEMORY) && mem_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_ir    <= 16'h0000;
            r_cc    <= 4'b0000;
            r_count <= '0;
        end else begin
            if (w_retire)
                r_count <= r_count + CNT_W'(1);
            case (r_state)
                ST_FETCH: begin
                    if (mem_ready) begin
                        r_ir    <= mem_data;
                        r_state <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    if (cc_en && (w_op != OP_BCC))
                        r_cc <= flags_in;
                    r_state <= (w_op == OP_LDST) ? ST_MEMORY : ST_FETCH;
                end
                ST_MEMORY: begin
                    if (mem_ready)
                        r_state <= ST_FETCH;
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    assign state        = r_state;
    assign ir           = r_ir;
    assign cc           = r_cc;
    assign instr_count  = r_count;
    assign retire       = w_retire;
    assign branch_taken = (r_state == ST_EXECUTE) && (w_op == OP_BCC) && w_cond_true;

endmodule

// File: tb/tb_stump_sequencer.sv
// tb/tb_stump_sequencer.sv - self-checking bench for stump_sequencer
module tb_stump_sequencer;
    import stump_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] mem_data = 16'h0000;
    logic        mem_ready = 1'b0;
    logic        cc_en = 1'b0;
    logic [3:0]  flags_in = 4'b0000;

    logic [1:0]  state, state4;
    logic [15:0] ir, ir4;
    logic [3:0]  cc, cc4;
    logic        branch_taken, branch_taken4;
    logic        retire, retire4;
    logic [15:0] instr_count;
    logic [3:0]  instr_count4;

    int errors = 0;
    int checks = 0;

    logic [3:0]  m_cc;
    logic [15:0] m_ir;
    int          m_count;

    typedef struct {
        logic [15:0] instr;
        logic        ce;
        logic [3:0]  fl;
        logic        exp_bt;
        logic [3:0]  exp_cc;
    } vec_t;

    vec_t vt[6];

    always #5 clk = ~clk;

    stump_sequencer #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .mem_data(mem_data), .mem_ready(mem_ready),
        .cc_en(cc_en), .flags_in(flags_in), .state(state), .ir(ir), .cc(cc),
        .branch_taken(branch_taken), .retire(retire), .instr_count(instr_count)
    );

    stump_sequencer #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .mem_data(mem_data), .mem_ready(mem_ready),
        .cc_en(cc_en), .flags_in(flags_in), .state(state4), .ir(ir4), .cc(cc4),
        .branch_taken(branch_taken4), .retire(retire4), .instr_count(instr_count4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, v, cy;
        n = f[3]; z = f[2]; v = f[1]; cy = f[0];
        case (c)
            4'd0:  return 1'b1;
            4'd1:  return 1'b0;
            4'd2:  return !(cy || z);
            4'd3:  return cy || z;
            4'd4:  return !cy;
            4'd5:  return cy;
            4'd6:  return !z;
            4'd7:  return z;
            4'd8:  return !v;
            4'd9:  return v;
            4'd10: return !n;
            4'd11: return n;
            4'd12: return n == v;
            4'd13: return n != v;
            4'd14: return (n == v) && !z;
            default: return (n != v) || z;
        endcase
    endfunction

    task automatic model_reset();
        m_cc = 4'b0000;
        m_ir = 16'h0000;
        m_count = 0;
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_count"}, 32'(instr_count), 32'(m_count & 32'hFFFF));
        chk({tag, "_count4"}, 32'(instr_count4), 32'(m_count % 16));
        chk({tag, "_cc"}, 32'(cc), 32'(m_cc));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_state", 32'(state), 32'(ST_FETCH));
        chk("rst_ir", 32'(ir), 32'h0);
        chk("rst_cc", 32'(cc), 32'h0);
        chk("rst_count", 32'(instr_count), 32'h0);
        chk("rst_retire", 32'(retire), 32'h0);
        chk("rst_bt", 32'(branch_taken), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Executes one instruction with fw fetch and mw memory wait states, checking every cycle.
    task automatic run_instr(input logic [15:0] instr, input logic ce, input logic [3:0] fl,
                             input int fw, input int mw, output logic bt_seen);
        logic [2:0] op;
        op = instr[15:13];
        for (int i = 0; i < fw; i++) begin
            @(negedge clk);
            mem_ready = 1'b0; mem_data = 16'($urandom);
            cc_en = 1'($urandom); flags_in = 4'($urandom);
            #1;
            chk("fwait_state", 32'(state), 32'(ST_FETCH));
            chk("fwait_retire", 32'(retire), 32'h0);
            chk("fwait_ir", 32'(ir), 32'(m_ir));
            chk("fwait_bt", 32'(branch_taken), 32'h0);
        end
        @(negedge clk);
        mem_ready = 1'b1; mem_data = instr;
        cc_en = 1'($urandom); flags_in = 4'($urandom);
        #1;
        chk("fetch_state", 32'(state), 32'(ST_FETCH));
        chk("fetch_retire", 32'(retire), 32'h0);
        @(negedge clk);
        mem_ready = 1'($urandom); mem_data = 16'($urandom);
        cc_en = ce; flags_in = fl;
        #1;
        m_ir = instr;
        bt_seen = branch_taken;
        chk("exec_state", 32'(state), 32'(ST_EXECUTE));
        chk("exec_ir", 32'(ir), 32'(instr));
        chk("exec_bt", 32'(branch_taken), 32'((op == 3'b110) && ref_cond(instr[11:8], m_cc)));
        chk("exec_retire", 32'(retire), 32'(op != 3'b111));
        if (ce && op != 3'b110)
            m_cc = fl;
        if (op != 3'b111) begin
            m_count++;
        end else begin
            for (int i = 0; i < mw; i++) begin
                @(negedge clk);
                mem_ready = 1'b0; cc_en = 1'($urandom); flags_in = 4'($urandom);
                #1;
                chk("mwait_state", 32'(state), 32'(ST_MEMORY));
                chk("mwait_retire", 32'(retire), 32'h0);
                chk("mwait_cc", 32'(cc), 32'(m_cc));
            end
            @(negedge clk);
            mem_ready = 1'b1; cc_en = 1'($urandom); flags_in = 4'($urandom);
            #1;
            chk("mem_state", 32'(state), 32'(ST_MEMORY));
            chk("mem_retire", 32'(retire), 32'h1);
            chk("mem_bt", 32'(branch_taken), 32'h0);
            m_count++;
        end
        @(posedge clk);
        #1;
        chk("post_state", 32'(state), 32'(ST_FETCH));
        check_counts("post");
    endtask

    initial begin
        logic bt;
        logic [15:0] w;

        vt[0] = '{16'h4000, 1'b1, 4'b0100, 1'b0, 4'b0100};
        vt[1] = '{16'h0000, 1'b0, 4'b1000, 1'b0, 4'b0100};
        vt[2] = '{16'hC700, 1'b1, 4'b1111, 1'b1, 4'b0100};
        vt[3] = '{16'h0000, 1'b1, 4'b0000, 1'b0, 4'b0000};
        vt[4] = '{16'hC700, 1'b0, 4'b0000, 1'b0, 4'b0000};
        vt[5] = '{16'hC600, 1'b1, 4'b0100, 1'b1, 4'b0000};

        do_reset();

        run_instr(16'h0123, 1'b0, 4'b0000, 0, 0, bt);
        chk("add_ir", 32'(ir), 32'h0123);
        chk("add_count", 32'(instr_count), 32'd1);

        run_instr(16'hE800, 1'b0, 4'b0000, 0, 2, bt);
        chk("ldst_count", 32'(instr_count), 32'd2);

        foreach (vt[i]) begin
            run_instr(vt[i].instr, vt[i].ce, vt[i].fl, 0, 0, bt);
            chk("vec_bt", 32'(bt), 32'(vt[i].exp_bt));
            chk("vec_cc", 32'(cc), 32'(vt[i].exp_cc));
        end

        for (int f = 0; f < 16; f++) begin
            run_instr(16'h4000, 1'b1, 4'(f), 0, 0, bt);
            for (int c = 0; c < 16; c++) begin
                w = {3'b110, 1'b0, 4'(c), 8'h00};
                run_instr(w, 1'b1, 4'(~f), 0, 0, bt);
            end
        end

        for (int k = 0; k < 40; k++) begin
            w = 16'($urandom);
            run_instr(w, 1'($urandom), 4'($urandom), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)), bt);
        end

        // Reset between edges while a load/store is parked in MEMORY.
        @(negedge clk);
        mem_ready = 1'b1; mem_data = 16'hE123;
        @(negedge clk);
        mem_ready = 1'b0; cc_en = 1'b1; flags_in = 4'b1010;
        @(negedge clk);
        #1;
        chk("mid_state", 32'(state), 32'(ST_MEMORY));
        chk("mid_cc", 32'(cc), 32'hA);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_state", 32'(state), 32'(ST_FETCH));
        chk("arst_ir", 32'(ir), 32'h0);
        chk("arst_cc", 32'(cc), 32'h0);
        chk("arst_count", 32'(instr_count), 32'h0);
        chk("arst_retire", 32'(retire), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 15; k++)
            run_instr(16'h0001, 1'b0, 4'b0000, 0, 0, bt);
        chk("wrap_pre", 32'(instr_count4), 32'd15);
        run_instr(16'h0002, 1'b0, 4'b0000, 0, 0, bt);
        chk("wrap_post", 32'(instr_count4), 32'd0);
        chk("wrap_wide", 32'(instr_count), 32'd16);

        @(negedge clk);
        mem_ready = 1'b0;
        force dut.r_state = ST_ILLEGAL;
        #1;
        chk("ill_state", 32'(state), 32'(ST_ILLEGAL));
        chk("ill_retire", 32'(retire), 32'h0);
        chk("ill_bt", 32'(branch_taken), 32'h0);
        release dut.r_state;
        @(posedge clk);
        #1;
        chk("ill_next", 32'(state), 32'(ST_FETCH));
        chk("ill_ir", 32'(ir), 32'h0002);
        chk("ill_count", 32'(instr_count), 32'd16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
